// File: rtl/fp_int_mul_seq.sv
// Job sequencer for one bit-serial FP16 x INT multiplier: it holds the activation,
// shifts the weight out MSB-first, then captures the product onto a valid/ready output.
module fp_int_mul_seq #(
    parameter int ACT_WIDTH = 16,
    parameter int MAX_PREC  = 8,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 14,
    parameter int TIMEOUT   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_precision,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [MAX_PREC-1:0]  in_w,
    output logic [ACT_WIDTH-1:0] mul_act,
    output logic                 mul_w,
    output logic                 mul_valid,
    output logic [3:0]           mul_precision,
    input  logic                 mul_sign,
    input  logic [EXP_WIDTH-1:0] mul_exp,
    input  logic [MAN_WIDTH-1:0] mul_mantissa,
    input  logic                 mul_start_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic [MAN_WIDTH-1:0] out_mantissa,
    output logic                 busy,
    output logic                 err_cfg,
    output logic                 err_timeout
);

    localparam int CNT_W = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

    state_t              state, state_nxt;
    logic [MAX_PREC-1:0] w_lat;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_init;
    logic [WD_W-1:0]     wd;
    logic                accept, last_bit, capture, expire, cfg_ok, cfg_bad;

    assign in_ready = (state == IDLE) && !out_valid && !cfg_we;
    assign busy     = (state != IDLE);
    assign cnt_init = CNT_W'(mul_precision - 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        cfg_ok    = 1'b0;
        cfg_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_we) begin
                    if (cfg_precision != 4'd0 && int'(cfg_precision) <= MAX_PREC) cfg_ok = 1'b1;
                    else                                                          cfg_bad = 1'b1;
                end else if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                last_bit = (cnt == '0);
                // A result strobe is only meaningful once the final weight bit is on the wire.
                if (last_bit) begin
                    capture   = mul_start_acc;
                    state_nxt = mul_start_acc ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mul_start_acc) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_act       <= '0;
            mul_w         <= 1'b0;
            mul_valid     <= 1'b0;
            mul_precision <= 4'd4;
            w_lat         <= '0;
            cnt           <= '0;
            wd            <= '0;
            out_valid     <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_mantissa  <= '0;
            err_cfg       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            if (cfg_ok)  mul_precision <= cfg_precision;
            if (cfg_bad) err_cfg       <= 1'b1;

            if (accept) begin
                mul_act   <= in_act;
                w_lat     <= in_w;
                cnt       <= cnt_init;
                mul_valid <= 1'b1;
                mul_w     <= in_w[cnt_init];
            end

            if (state == SHIFT) begin
                if (last_bit) begin
                    mul_valid <= 1'b0;
                    mul_w     <= 1'b0;
                    wd        <= '0;
                end else begin
                    cnt   <= cnt - CNT_W'(1);
                    mul_w <= w_lat[cnt - CNT_W'(1)];
                end
            end

            if (state == WAIT && !capture && !expire) wd <= wd + WD_W'(1);

            if (capture) begin
                out_valid    <= 1'b1;
                out_sign     <= mul_sign;
                out_exp      <= mul_exp;
                out_mantissa <= mul_mantissa;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (expire) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_int_mul_seq.sv
// Directed plus randomized bench for fp_int_mul_seq; the bench plays the multiplier and
// predicts the serial weight stream and captured product from plain integer arithmetic.
module tb_fp_int_mul_seq;

    localparam int TIMEOUT = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_precision;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [7:0]  in_w;
    logic [15:0] mul_act;
    logic        mul_w;
    logic        mul_valid;
    logic [3:0]  mul_precision;
    logic        mul_sign;
    logic [4:0]  mul_exp;
    logic [13:0] mul_mantissa;
    logic        mul_start_acc;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [4:0]  out_exp;
    logic [13:0] out_mantissa;
    logic        busy;
    logic        err_cfg;
    logic        err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    int model_prec;
    bit model_err_cfg;
    bit model_err_to;

    fp_int_mul_seq #(
        .ACT_WIDTH(16), .MAX_PREC(8), .EXP_WIDTH(5), .MAN_WIDTH(14), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_precision(cfg_precision),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
        .mul_act(mul_act), .mul_w(mul_w), .mul_valid(mul_valid), .mul_precision(mul_precision),
        .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_mantissa(mul_mantissa),
        .mul_start_acc(mul_start_acc), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mantissa(out_mantissa),
        .busy(busy), .err_cfg(err_cfg), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic noise_product();
        mul_sign     = 1'($urandom);
        mul_exp      = 5'($urandom);
        mul_mantissa = 14'($urandom);
    endtask

    task automatic check_status();
        check("mul_precision", 32'(mul_precision), 32'(model_prec));
        check("err_cfg", 32'(err_cfg), 32'(model_err_cfg));
        check("err_timeout", 32'(err_timeout), 32'(model_err_to));
    endtask

    task automatic cfg_write(input int p);
        @(negedge clk);
        cfg_we        = 1'b1;
        cfg_precision = 4'(p);
        in_valid      = 1'b1;
        in_act        = 16'($urandom);
        #1 check("cfg_blocks_in_ready", 32'(in_ready), 32'd0);
        if (p >= 1 && p <= 8) model_prec = p;
        else                  model_err_cfg = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("cfg_no_job", 32'(busy), 32'd0);
        check_status();
    endtask

    // delay: 0 = strobe in final shift cycle, n>0 = strobe in n-th WAIT cycle, -1 = never.
    task automatic run_job(input logic [15:0] act, input logic [7:0] w, input int delay,
                           input logic sgn, input logic [4:0] ex, input logic [13:0] man,
                           input int hold, input bit cfg_in_shift);
        int bits[$];
        for (int i = model_prec - 1; i >= 0; i--) bits.push_back(int'((w >> i) & 8'd1));

        @(negedge clk);
        mul_start_acc = 1'b1;
        noise_product();
        @(negedge clk);
        mul_start_acc = 1'b0;
        check("idle_strobe_ignored", 32'(out_valid), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_act   = act;
        in_w     = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_act   = 16'($urandom);
        in_w     = 8'($urandom);

        for (int k = 0; k < bits.size(); k++) begin
            check("shift_valid", 32'(mul_valid), 32'd1);
            check("shift_bit", 32'(mul_w), 32'(bits[k]));
            check("shift_act", 32'(mul_act), 32'(act));
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_no_out", 32'(out_valid), 32'd0);
            if (k != bits.size() - 1) begin
                mul_start_acc = 1'($urandom_range(0, 1));
                noise_product();
            end else if (delay == 0) begin
                mul_start_acc = 1'b1;
                mul_sign      = sgn;
                mul_exp       = ex;
                mul_mantissa  = man;
            end else begin
                mul_start_acc = 1'b0;
            end
            if (cfg_in_shift && k == 0) begin
                cfg_we        = 1'b1;
                cfg_precision = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            cfg_we = 1'b0;
        end
        mul_start_acc = 1'b0;

        if (delay < 0) begin
            for (int d = 0; d < TIMEOUT; d++) begin
                check("wait_busy", 32'(busy), 32'd1);
                check("wait_no_out", 32'(out_valid), 32'd0);
                check("wait_mul_valid", 32'(mul_valid), 32'd0);
                @(negedge clk);
            end
            model_err_to = 1'b1;
            check("timeout_idle", 32'(busy), 32'd0);
            check("timeout_no_out", 32'(out_valid), 32'd0);
            check_status();
        end else begin
            for (int d = 1; d <= delay; d++) begin
                check("wait_mul_valid", 32'(mul_valid), 32'd0);
                check("wait_mul_w", 32'(mul_w), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
                check("wait_act_held", 32'(mul_act), 32'(act));
                if (d == delay) begin
                    mul_start_acc = 1'b1;
                    mul_sign      = sgn;
                    mul_exp       = ex;
                    mul_mantissa  = man;
                end
                @(negedge clk);
                mul_start_acc = 1'b0;
            end
            check("res_valid", 32'(out_valid), 32'd1);
            check("res_sign", 32'(out_sign), 32'(sgn));
            check("res_exp", 32'(out_exp), 32'(ex));
            check("res_man", 32'(out_mantissa), 32'(man));
            check("res_idle", 32'(busy), 32'd0);
            check("res_in_ready", 32'(in_ready), 32'd0);
            check("res_mul_valid", 32'(mul_valid), 32'd0);
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_act    = 16'($urandom);
                noise_product();
                @(negedge clk);
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_sign", 32'(out_sign), 32'(sgn));
                check("bp_exp", 32'(out_exp), 32'(ex));
                check("bp_man", 32'(out_mantissa), 32'(man));
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_no_job", 32'(busy), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("drain_valid", 32'(out_valid), 32'd0);
            check("drain_in_ready", 32'(in_ready), 32'd1);
            check_status();
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_precision = 4'd0; in_valid = 1'b0; in_act = '0; in_w = '0;
        mul_sign = 1'b0; mul_exp = '0; mul_mantissa = '0; mul_start_acc = 1'b0; out_ready = 1'b0;
        model_prec = 4; model_err_cfg = 1'b0; model_err_to = 1'b0;

        #2;
        check("rst_mul_valid", 32'(mul_valid), 32'd0);
        check("rst_mul_w", 32'(mul_w), 32'd0);
        check("rst_mul_act", 32'(mul_act), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_exp", 32'(out_exp), 32'd0);
        check("rst_out_man", 32'(out_mantissa), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check_status();
        @(negedge clk);
        rst = 1'b0;

        // Basic job with backpressure, then an 8-bit job captured in the final shift cycle.
        run_job(16'h1234, 8'b0000_1010, 2, 1'b0, 5'b00100, 14'b00111110000010, 5, 1'b0);
        cfg_write(8);
        run_job(16'h3C00, 8'hA5, 0, 1'b1, 5'h1F, 14'h2AAA, 1, 1'b0);
        cfg_write(0);
        cfg_write(9);
        run_job(16'hC500, 8'h5A, 3, 1'b1, 5'h0A, 14'h1357, 0, 1'b1);

        // Lost strobe, then the block must accept the next job.
        cfg_write(3);
        run_job(16'h4400, 8'h06, -1, 1'b0, 5'h00, 14'h0000, 0, 1'b0);
        run_job(16'h4800, 8'h05, 1, 1'b0, 5'h11, 14'h0F0F, 2, 1'b0);
        cfg_write(1);
        run_job(16'h0001, 8'hFE, 0, 1'b1, 5'h01, 14'h3FFF, 0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int dly;
            if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, 10)));
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run_job(16'($urandom), 8'($urandom), dly, 1'($urandom), 5'($urandom),
                    14'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a 4-bit shift.
        cfg_write(4);
        @(negedge clk);
        in_valid = 1'b1; in_act = 16'hBEEF; in_w = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_shift", 32'(mul_valid), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_prec = 4; model_err_cfg = 1'b0; model_err_to = 1'b0;
        check("mid_rst_mul_valid", 32'(mul_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_mul_act", 32'(mul_act), 32'd0);
        check_status();
        @(negedge clk);
        rst = 1'b0;
        run_job(16'h5A5A, 8'h09, 2, 1'b1, 5'h15, 14'h2468, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_int_mul_seq.md
Name: fp_int_mul_seq

Overview:
Sequencer that sits in front of one fp_int_mul bit-serial FP16 x INT multiplier. It accepts a parallel {activation, weight word} job over a valid/ready handshake and holds the activation stable. It serializes the weight MSB-first onto the multiplier's 1-bit weight input for `precision` cycles. It then captures the product {sign, exp, mantissa} when the multiplier pulses start_acc and presents the product on a valid/ready output. It also owns the multiplier's precision register and a watchdog for lost start_acc pulses.

Parameters:
ACT_WIDTH, 16, activation width (FP16)
MAX_PREC, 8, maximum weight bit-width; width of in_w
EXP_WIDTH, 5, product exponent width
MAN_WIDTH, 14, product mantissa width
TIMEOUT, 24, cycles allowed in WAIT before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  precision write strobe
cfg_precision  in  4  requested weight precision
in_valid  in  1  job valid
in_ready  out  1  job accepted when in_valid && in_ready
in_act  in  ACT_WIDTH  FP16 activation
in_w  in  MAX_PREC  weight word; bits [precision-1:0] used
mul_act  out  ACT_WIDTH  to multiplier act
mul_w  out  1  to multiplier w (serial weight bit)
mul_valid  out  1  to multiplier valid
mul_precision  out  4  to multiplier precision
mul_sign  in  1  from multiplier sign_out
mul_exp  in  EXP_WIDTH  from multiplier exp_out
mul_mantissa  in  MAN_WIDTH  from multiplier mantissa_out
mul_start_acc  in  1  from multiplier start_acc (result strobe)
out_valid  out  1  product valid
out_ready  in  1  consumer ready
out_sign  out  1  captured sign
out_exp  out  EXP_WIDTH  captured exponent
out_mantissa  out  MAN_WIDTH  captured mantissa
busy  out  1  high in SHIFT or WAIT
err_cfg  out  1  sticky: illegal precision write
err_timeout  out  1  sticky: start_acc never arrived

Behaviour:
- Reset (async, any state): state=IDLE; mul_valid=0, mul_w=0, mul_act=0, mul_precision=4; out_valid=0; out_sign/exp/mantissa=0; bit counter=0; err_cfg=0, err_timeout=0. All outputs are registered except in_ready and busy.
- Config: cfg_we is honoured only in IDLE. A value in 1..MAX_PREC updates mul_precision on the next edge. A value of 0 or >MAX_PREC leaves mul_precision unchanged and sets err_cfg. cfg_we in SHIFT/WAIT is ignored and sets no error. err_cfg and err_timeout clear only on rst.
- in_ready = (state==IDLE) && !out_valid && !cfg_we. A config write takes priority over a job in the same cycle.
- FSM states: IDLE, SHIFT, WAIT.
- IDLE -> SHIFT on accept at edge N: latch in_act into mul_act, latch in_w, set counter = mul_precision-1.
- SHIFT: cycles N+1..N+P (P = mul_precision). mul_valid=1 and mul_w = w_latched[counter]; counter decrements each edge. The last bit is bit 0. After P cycles, go to WAIT with mul_valid=0 and mul_w=0.
- WAIT: mul_valid=0 and mul_act is held.
  - On mul_start_acc=1, capture mul_sign/exp/mantissa into out_*, set out_valid=1, go to IDLE.
  - A start_acc arriving during the final SHIFT cycle is also captured; the FSM then goes directly to IDLE.
  - The watchdog counts cycles in WAIT. On reaching TIMEOUT, set err_timeout, go to IDLE, and do not raise out_valid.
- mul_start_acc in IDLE, or in SHIFT before the last bit, is ignored.
- Output handshake: out_valid stays high with out_* stable until out_valid && out_ready, then clears on the next edge. Because in_ready=0 while out_valid=1, only one job is ever in flight and the output buffer is always empty at capture.
- mul_valid is guaranteed low for at least 1 cycle between jobs, which re-arms the multiplier.
- Minimum job throughput is P+2 cycles plus the multiplier's result latency.

Test Plan:
- Reset defaults: assert rst mid-cycle -> all outputs at reset values immediately (async); mul_precision=4.
- Basic job: precision 4, in_act=0x1234, in_w=4'b1010 -> mul_valid high for exactly 4 cycles, mul_w=1,0,1,0, mul_act=0x1234. Then model start_acc with sign=0, exp=5'b00100, mantissa=14'b00111110000010 -> out_valid=1 with those values; in_ready=0 until out_ready.
- Backpressure: hold out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0, second job not accepted; out_ready=1 -> out_valid drops next edge, in_ready rises.
- Config: cfg_precision=8 in IDLE -> mul_precision=8 and next job shifts 8 bits (in_w=0xA5 -> 1,0,1,0,0,1,0,1). cfg_precision=0 or 9 -> mul_precision unchanged, err_cfg=1. cfg_we during SHIFT -> ignored.
- Timeout: never pulse start_acc -> after TIMEOUT=24 WAIT cycles, err_timeout=1, state IDLE, out_valid stays 0, next job accepted.
- Reset mid-SHIFT: rst after 2 of 4 bits -> mul_valid=0 immediately; after release, a new job shifts a full 4 bits.
